alarm_bank: RTL

ALARM_BANK -- requirements
Module: alarm_bank

---
 rtl/alarm_bank.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - bank of time-of-day alarm channels with snooze and ring timeout
// Ports:
//   clk                  clock, all state changes on rising edge
//   rst                  synchronous active-low reset
//   sec_tick             one-cycle pulse per second, advances the ring timeout
//   curr_minutes/hours   current time of day
//   set_alarm            write strobe for set_idx / set_minutes / set_hours / set_enable
//   snooze, dismiss      strobes acting on every ringing channel (dismiss also cancels snoozed)
//   alarm_trigger        registered: some channel is ringing
//   alarm_idx            registered: lowest ringing channel, 0 when none
//   alarm_enabled        registered: per-channel enable bits
module alarm_bank #(
    parameter int N_ALARMS   = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    localparam int IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick,
    input  logic [6:0]          curr_minutes,
    input  logic [5:0]          curr_hours,
    input  logic                set_alarm,
    input  logic [IW-1:0]       set_idx,
    input  logic [6:0]          set_minutes,
    input  logic [5:0]          set_hours,
    input  logic                set_enable,
    input  logic                snooze,
    input  logic                dismiss,
    output logic                alarm_trigger,
    output logic [IW-1:0]       alarm_idx,
    output logic [N_ALARMS-1:0] alarm_enabled
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    logic                wr_ok;
    logic [7:0]          snz_sum;
    logic [6:0]          snz_min_calc;
    logic [5:0]          snz_hr_calc;
    logic [N_ALARMS-1:0] ringing;
    logic [N_ALARMS-1:0] en_vec;
    logic                trig_d;
    logic [IW-1:0]       idx_d;

    // Out-of-range writes are dropped entirely rather than clamped.
    assign wr_ok = set_alarm && (int'(set_idx) < N_ALARMS) &&
                   (set_minutes <= 7'd59) && (set_hours <= 6'd23);

    // Snooze target is shared: every channel snoozed on the same edge gets the same time.
    assign snz_sum = {1'b0, curr_minutes} + 8'(SNOOZE_MIN);

    always_comb begin
        snz_min_calc = snz_sum[6:0];
        snz_hr_calc  = curr_hours;
        if (snz_sum >= 8'd60) begin
            snz_min_calc = 7'(snz_sum - 8'd60);
            snz_hr_calc  = (curr_hours == 6'd23) ? 6'd0 : curr_hours + 6'd1;
        end
    end

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_ch
        state_t     state_q, state_d;
        logic [6:0] alarm_min_q, alarm_min_d, snz_min_q, snz_min_d;
        logic [5:0] alarm_hr_q, alarm_hr_d, snz_hr_q, snz_hr_d;
        logic       en_q, en_d;
        logic [7:0] ring_cnt_q, ring_cnt_d;
        logic       match_prev_q, snz_prev_q;
        logic       match_now, snz_now, wr_hit, timeout;

        assign wr_hit    = wr_ok && (int'(set_idx) == g);
        assign match_now = en_q && (curr_minutes == alarm_min_q) && (curr_hours == alarm_hr_q);
        assign snz_now   = (curr_minutes == snz_min_q) && (curr_hours == snz_hr_q);
        // The tick that would bring the count to RING_SEC ends the ring instead.
        assign timeout   = sec_tick && (({1'b0, ring_cnt_q} + 9'd1) == 9'(RING_SEC));

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q      <= ST_IDLE;
                alarm_min_q  <= '0;
                alarm_hr_q   <= '0;
                en_q         <= 1'b0;
                snz_min_q    <= '0;
                snz_hr_q     <= '0;
                ring_cnt_q   <= '0;
                // History starts high so a time already matching does not fire right after reset.
                match_prev_q <= 1'b1;
                snz_prev_q   <= 1'b1;
            end else begin
                state_q      <= state_d;
                alarm_min_q  <= alarm_min_d;
                alarm_hr_q   <= alarm_hr_d;
                en_q         <= en_d;
                snz_min_q    <= snz_min_d;
                snz_hr_q     <= snz_hr_d;
                ring_cnt_q   <= ring_cnt_d;
                match_prev_q <= match_now;
                snz_prev_q   <= snz_now;
            end
        end

        always_comb begin
            state_d     = state_q;
            alarm_min_d = alarm_min_q;
            alarm_hr_d  = alarm_hr_q;
            en_d        = en_q;
            snz_min_d   = snz_min_q;
            snz_hr_d    = snz_hr_q;
            ring_cnt_d  = ring_cnt_q;
            if (wr_hit) begin
                alarm_min_d = set_minutes;
                alarm_hr_d  = set_hours;
                en_d        = set_enable;
                state_d     = ST_IDLE;
            end else if (!en_q) begin
                state_d = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (match_now && !match_prev_q) begin
                            state_d    = ST_RINGING;
                            ring_cnt_d = '0;
                        end
                    end
                    ST_RINGING: begin
                        if (dismiss || timeout) begin
                            state_d = ST_IDLE;
                        end else if (snooze) begin
                            state_d   = ST_SNOOZED;
                            snz_min_d = snz_min_calc;
                            snz_hr_d  = snz_hr_calc;
                        end else if (sec_tick) begin
                            ring_cnt_d = ring_cnt_q + 8'd1;
                        end
                    end
                    ST_SNOOZED: begin
                        if (dismiss) begin
                            state_d = ST_IDLE;
                        end else if (snz_now && !snz_prev_q) begin
                            state_d    = ST_RINGING;
                            ring_cnt_d = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        assign ringing[g] = (state_q == ST_RINGING);
        assign en_vec[g]  = en_q;
    end

    always_comb begin
        trig_d = |ringing;
        idx_d  = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) idx_d = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_trigger <= 1'b0;
            alarm_idx     <= '0;
            alarm_enabled <= '0;
        end else begin
            alarm_trigger <= trig_d;
            alarm_idx     <= idx_d;
            alarm_enabled <= en_vec;
        end
    end

endmodule
